pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage pipeline. Each cycle it decides whether the PC advances and whether each inter-stage latch (IF/ID, ID/EX, EX/MEM, MEM/WB) loads, holds (stall), zeroes (flush) or takes a bubble. It covers data-cache waits, taken-branch redirects, load-use hazards, instruction-cache misses and halt drain. It also keeps saturating stall and flush performance counters.

## Interface
- CNT_W, 32, width of performance counters
- REG_W, 5, register-address width
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- ihit  in  1  instruction fetch valid this cycle
- dhit  in  1  data access completes this cycle; ignored with no MEM request
- mem_dREN, mem_dWEN  in  1 each  EX/MEM instruction requests data read / write
- ex_dREN  in  1  ID/EX instruction is a load
- ex_rt  in  REG_W  load destination in ID/EX
- id_rs, id_rt  in  REG_W  source registers of IF/ID instruction
- id_uses_rt  in  1  IF/ID instruction reads rt
- branch_taken  in  1  EX resolved a taken branch/jump (PC mux selects target)
- halt_mem  in  1  EX/MEM holds halt
- pc_en  out  1  PC register loads next value
- if_id_stall, if_id_flush  out  1 each
- id_ex_stall, id_ex_flush, id_ex_bubble  out  1 each
- ex_mem_stall, ex_mem_flush  out  1 each
- mem_wb_flush  out  1
- halt  out  1  processor halted (sticky)
- stall_cycles  out  CNT_W  cycles with pc_en=0 outside HALTED
- flush_count  out  CNT_W  taken-branch redirects

## Operation
- FSM states: RUN, DWAIT, HALTED. Outputs are combinational from state plus inputs. Counters are registered.
- Unlisted control outputs are 0. Latch priority is flush/bubble over stall, consistent with the latch modules.
- dwait = (mem_dREN | mem_dWEN) & ~dhit.
- load_use = ex_dREN & ex_rt≠0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- RUN and DWAIT evaluate conditions in this priority order; the first match wins:
  1. halt_mem: pc_en=0, if_id_flush, id_ex_flush, ex_mem_flush. MEM/WB loads the halt. Next state HALTED.
  2. dwait: pc_en=0, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush. Next state DWAIT.
  3. branch_taken: pc_en=1, if_id_flush, id_ex_flush, flush_count+1. pc_en=1 even if ihit=0. Next state RUN.
  4. load_use: pc_en=0, if_id_stall, id_ex_bubble. Next state RUN.
  5. ~ihit: pc_en=0, if_id_flush. Next state RUN.
  6. Otherwise: pc_en=1, all other controls 0. Next state RUN.
- In DWAIT, when dhit=1 the cycle falls through to rules 3–6 and the next state is RUN. ihit is ignored while dwait holds.
- HALTED: pc_en=0, all *_stall=1, halt=1, flush and bubble outputs 0. Only RST exits. Counters freeze.
- Counters saturate at 2^CNT_W−1 and never wrap. stall_cycles increments in any RUN/DWAIT cycle with pc_en=0, including the halt_mem cycle.

## Timing
- Decisions have zero-cycle latency: outputs are valid in the same cycle as their inputs, and latches act on the next CLK edge.
- Counters and state update on that same edge; stall_cycles and flush_count reflect a cycle's event one cycle later.
- Load-use inserts exactly one bubble, because the following cycle ID/EX holds a nop and load_use drops.
- Simultaneous events resolve by the priority list:
  - Branch during dwait: no redirect; branch_taken is re-evaluated once dhit arrives.
  - Branch plus load-use: branch wins.
  - dhit in the same cycle as the request: no stall.
- Reset: RST=1 at an edge forces state RUN, halt=0 and both counters to 0, including mid-DWAIT or in HALTED.
- While RST=1, outputs follow RUN rules on live inputs.

## Structure
- Shared package: enum hz_state_t {RUN, DWAIT, HALTED} and a REG_W default constant. These are added to cpu_types_pkg.
- Sub-module sat_counter (parameter W; inputs CLK, RST, inc; output count) is instantiated twice.

## Test plan
- Load-use: ex_dREN=1, ex_rt=5, id_rs=5, ihit=1 -> one cycle of pc_en=0, if_id_stall=1, id_ex_bubble=1, then pc_en=1. stall_cycles=1.
- Dcache miss: mem_dREN=1 with dhit=0 for 3 cycles, then dhit=1 -> id_ex_stall and mem_wb_flush high for 3 cycles, then RUN. stall_cycles=3.
- Branch with ihit=0: branch_taken=1 -> pc_en=1, if_id_flush=1, id_ex_flush=1. flush_count=1 next cycle.
- Branch during dwait: branch_taken=1, mem_dWEN=1, dhit=0 for 2 cycles -> no flush. Flush occurs on the dhit cycle.
- Halt: halt_mem=1 -> ex_mem_flush=1 that cycle, then halt=1 and all stalls high indefinitely. Counters frozen.
- Reset mid-DWAIT and mid-HALTED: RST=1 for 1 cycle -> state RUN, halt=0, both counters 0. Counter saturation is checked with CNT_W=3: 9 stall cycles -> stall_cycles=7.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: hazard controller states and register width
package cpu_types_pkg;

    localparam int HZ_REG_W = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, sticking at all-ones instead of wrapping
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - PC enable and inter-stage latch control for the 5-stage pipeline
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = HZ_REG_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             branch_taken,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_stall,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    hz_state_t state;
    hz_state_t state_next;
    logic      dwait;
    logic      load_use;
    logic      halted_eff;
    logic      stall_inc;
    logic      flush_inc;

    assign dwait    = (mem_dREN | mem_dWEN) & ~dhit;
    assign load_use = ex_dREN && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // While reset is held the controller behaves as if in RUN, even from HALTED
    assign halted_eff = (state == HALTED) && !RST;
    assign halt       = halted_eff;

    // Priority decode of the current cycle's hazard; RUN and DWAIT share it
    always_comb begin
        pc_en        = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        flush_inc    = 1'b0;
        state_next   = state;
        if (halted_eff) begin
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (halt_mem) begin
            // Younger stages are squashed; MEM/WB still loads the halt itself
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_next   = HALTED;
        end else if (dwait) begin
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
            state_next   = DWAIT;
        end else if (branch_taken) begin
            // Redirect regardless of ihit: the target fetch is what matters
            pc_en       = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
            state_next  = RUN;
        end else if (load_use) begin
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            state_next   = RUN;
        end else if (!ihit) begin
            if_id_flush = 1'b1;
            state_next  = RUN;
        end else begin
            pc_en      = 1'b1;
            state_next = RUN;
        end
    end

    assign stall_inc = !halted_eff && !pc_en;

    // State register; reset returns to RUN from anywhere
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule
